// File: rtl/pll_divgen_pkg.sv
// pll_divgen_pkg: shared state, config record and request validation for pll_divgen_multi
package pll_divgen_pkg;
  localparam int CFG_CHAN_W = 4;
  localparam int CFG_FIELD_W = 32;
  typedef enum logic [1:0] {INIT, LOCKING, LOCKED} state_t;
  typedef struct packed {
    logic [CFG_CHAN_W-1:0]  chan;
    logic [CFG_FIELD_W-1:0] div;
    logic [CFG_FIELD_W-1:0] high;
    logic [CFG_FIELD_W-1:0] phase;
  } cfg_t;
  function automatic bit cfg_ok(input cfg_t c, input int unsigned n);
    return c.div >= 2 && c.high != 0 && c.high < c.div && c.phase < c.div && 32'(c.chan) < n;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided-clock channel with programmable div/high/phase and realignment
module clk_div_chan #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             realign,
  input  logic             gate,
  input  logic [DIV_W-1:0] new_div,
  input  logic [DIV_W-1:0] new_high,
  input  logic [DIV_W-1:0] new_phase,
  output logic             outclk,
  output logic             outclk_en
);
  logic [DIV_W-1:0] div, high, phase, cnt;
  logic [DIV_W-1:0] div_n, high_n, phase_n, cnt_n;
  always_comb begin
    div_n   = load ? new_div : div;
    high_n  = load ? new_high : high;
    phase_n = load ? new_phase : phase;
    cnt_n   = realign ? phase_n : cnt >= div - DIV_W'(1) ? '0 : cnt + DIV_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= DIV_W'(DEFAULT_DIV);
      high      <= DIV_W'(DEFAULT_HIGH);
      phase     <= '0;
      cnt       <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      div       <= div_n;
      high      <= high_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      outclk    <= gate && cnt_n < high_n;
      outclk_en <= gate && cnt_n == '0;
    end
  end
endmodule

// File: rtl/pll_divgen_multi.sv
// pll_divgen_multi: lock FSM and config handshake driving NUM_CLOCKS realignable divided clocks
module pll_divgen_multi
  import pll_divgen_pkg::*;
#(
  parameter int NUM_CLOCKS    = 4,
  parameter int DIV_W         = 8,
  parameter int DEFAULT_DIV   = 2,
  parameter int DEFAULT_HIGH  = 1,
  parameter int LOCK_CYCLES   = 16,
  parameter int GATE_UNLOCKED = 1,
  localparam int CW = NUM_CLOCKS > 1 ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CW-1:0]         cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  state_t state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  cfg_t req;
  logic xfer, ok, accept, realign, gate;
  assign cfg_ready = !rst && state != INIT;
  assign locked = state == LOCKED;
  always_comb begin
    req        = '0;
    req.chan   = CFG_CHAN_W'(cfg_chan);
    req.div    = CFG_FIELD_W'(cfg_div);
    req.high   = CFG_FIELD_W'(cfg_high);
    req.phase  = CFG_FIELD_W'(cfg_phase);
    xfer       = cfg_valid && cfg_ready;
    ok         = cfg_ok(req, NUM_CLOCKS);
    accept     = xfer && ok;
    realign    = accept || state == INIT;
    state_n    = realign ? LOCKING : state == LOCKING && lock_cnt == LW'(LOCK_CYCLES - 1) ? LOCKED : state;
    lock_cnt_n = state == LOCKING && !accept ? lock_cnt + LW'(1) : '0;
    gate       = GATE_UNLOCKED == 0 || state_n == LOCKED;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= INIT;
      lock_cnt <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
      cfg_err  <= xfer && !ok;
    end
  end
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W(DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_chan (
      .clk(refclk),
      .rst(rst),
      .load(accept && cfg_chan == CW'(i)),
      .realign(realign),
      .gate(gate),
      .new_div(cfg_div),
      .new_high(cfg_high),
      .new_phase(cfg_phase),
      .outclk(outclk[i]),
      .outclk_en(outclk_en[i])
    );
  end
endmodule

// File: tb/tb_pll_divgen_multi.sv
// tb_pll_divgen_multi: directed self-checking bench for pll_divgen_multi (3 channels)
module tb_pll_divgen_multi;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic cfg_ready, cfg_err, locked;
  logic [2:0] outclk, outclk_en;
  int checks = 0, failures = 0, age = -1;
  int bdiv[3], bhigh[3], bphase[3];
  logic exp_err = 1'b0;
  pll_divgen_multi #(.NUM_CLOCKS(3)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );
  always #5 refclk = ~refclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [5:0] model();
    logic [2:0] oc, en;
    int c;
    oc = '0;
    en = '0;
    if (age >= 16)
      for (int i = 0; i < 3; i++) begin
        c = (bphase[i] + age) % bdiv[i];
        oc[i] = c < bhigh[i];
        en[i] = c == 0;
      end
    return {oc, en};
  endfunction
  task automatic step();
    @(posedge refclk);
    #1;
    age++;
  endtask
  task automatic check(input string tag);
    chk({tag, ".locked"}, locked, age >= 16);
    chk({tag, ".out"}, {outclk, outclk_en}, model());
    chk({tag, ".ready"}, cfg_ready, age >= 0);
    chk({tag, ".err"}, cfg_err, exp_err);
  endtask
  task automatic run(input int n, input string tag);
    repeat (n) begin
      step();
      check(tag);
    end
  endtask
  task automatic send(input int c, input int d, input int h, input int p, input bit accept, input string tag);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(c);
    cfg_div   = 8'(d);
    cfg_high  = 8'(h);
    cfg_phase = 8'(p);
    chk({tag, ".ready_req"}, cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    if (accept) begin
      age = 0;
      bdiv[c] = d;
      bhigh[c] = h;
      bphase[c] = p;
    end
    exp_err = !accept;
    check(tag);
    exp_err = 1'b0;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge refclk);
      #1;
      chk("rst.all_zero", {locked, outclk, outclk_en, cfg_ready, cfg_err}, '0);
    end
    for (int i = 0; i < 3; i++) begin
      bdiv[i] = 2;
      bhigh[i] = 1;
      bphase[i] = 0;
    end
    rst = 1'b0;
    age = -1;
    check("init");
  endtask
  initial begin
    do_reset(3);
    run(16, "lock0");
    step();
    check("lock0_edge");
    chk("lock0_c17", {outclk, outclk_en}, 6'b111_111);
    step();
    check("run0");
    chk("lock0_c18", {outclk, outclk_en}, 6'b000_000);
    run(6, "run0");
    send(1, 5, 2, 0, 1'b1, "p1");
    run(15, "p1_lock");
    step();
    check("p1_edge");
    chk("p1_t17", {outclk, outclk_en}, 6'b111_101);
    run(9, "p1_run");
    send(0, 4, 1, 0, 1'b1, "ph0");
    send(2, 4, 1, 2, 1'b1, "ph2");
    run(16, "ph_lock");
    chk("ph_ch0_en", {outclk, outclk_en}, 6'b011_001);
    run(2, "ph_run");
    chk("ph_ch2_en", {outclk, outclk_en}, 6'b100_100);
    run(6, "ph_run");
    send(0, 1, 1, 0, 1'b0, "bad_div");
    run(1, "bad_div_gap");
    send(1, 5, 5, 0, 1'b0, "bad_high_eq_div");
    run(1, "bad_high_gap");
    send(1, 5, 2, 5, 1'b0, "bad_phase");
    run(1, "bad_phase_gap");
    send(3, 2, 1, 0, 1'b0, "bad_chan");
    run(1, "bad_chan_gap");
    send(0, 4, 0, 0, 1'b0, "bad_high0");
    run(4, "bad_after");
    send(1, 3, 1, 0, 1'b1, "t1");
    run(7, "t1_lock");
    send(1, 5, 2, 1, 1'b1, "t2");
    run(17, "t2_lock");
    run(4, "t2_run");
    send(2, 3, 2, 1, 1'b1, "pre_rst");
    run(5, "pre_rst_lock");
    do_reset(2);
    run(16, "relock");
    step();
    check("relock_edge");
    chk("relock_c17", {outclk, outclk_en}, 6'b111_111);
    run(6, "relock_run");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
